fir_filter_window_mac: RTL and testbench

Upstream feeder for `fir_filter_acc_output`. The block accepts a raster-order RGB888 pixel stream and builds a 3x3 sliding window from two line buffers. It multiplies each window pixel by a per-tap signed coefficient and drives the 27 signed tap products together with the `mac_en`, `mac_clr` and `output_en` controls that the accumulator/saturation stage consumes. Only fully interior windows are produced ("valid" convolution). The frame ends with one flush pulse so the accumulator's two-stage pipe drains.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_line_buffer.sv | 29 ++
 rtl/fir_filter_window_mac.sv | 268 ++++++++++++++++++++++++++
 tb/tb_fir_filter_window_mac.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the 3x3 RGB window MAC feeder.
// Holds data widths, FSM states and the tap multiply.
package fir_pkg;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 8;
    localparam int TAP_W  = 17;
    localparam int NTAPS  = 9;

    typedef enum logic [1:0] {
        S_STREAM,
        S_FLUSH,
        S_DRAIN
    } state_e;

    typedef logic signed [TAP_W-1:0] tap_t;

    // Unsigned 8-bit pixel times signed 8-bit coefficient, 17-bit signed.
    function automatic tap_t tap_mul(
        input logic [PIX_W-1:0]         p,
        input logic signed [COEF_W-1:0] c
    );
        tap_t a;
        tap_t b;
        a = {{(TAP_W-PIX_W){1'b0}}, p};
        b = {{(TAP_W-COEF_W){c[COEF_W-1]}}, c};
        return a * b;
    endfunction

endpackage

// File: rtl/fir_line_buffer.sv
// Two-line delay for 24-bit pixels, addressed by column.
// Line2 takes the old line1 entry in the same write.
module fir_line_buffer #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [23:0]   din_i,
    output logic [23:0]   line1_o,
    output logic [23:0]   line2_o
);

    logic [23:0] l1_mem [DEPTH];
    logic [23:0] l2_mem [DEPTH];

    assign line1_o = l1_mem[addr_i];
    assign line2_o = l2_mem[addr_i];

    // Shift the column down one line on every accepted pixel.
    always_ff @(posedge clk) begin
        if (we_i) begin
            l1_mem[addr_i] <= din_i;
            l2_mem[addr_i] <= l1_mem[addr_i];
        end
    end

endmodule

// File: rtl/fir_filter_window_mac.sv
// 3x3 sliding window over an RGB888 raster with per-tap products.
// Feeds the accumulator with mac_en/mac_clr/output_en and a flush.
module fir_filter_window_mac
    import fir_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [23:0]             pixel_in,
    input  logic                    pixel_valid,
    output logic                    pixel_ready,
    input  logic [71:0]             coef_flat,
    output logic signed [TAP_W-1:0] filter_r_t0,
    output logic signed [TAP_W-1:0] filter_r_t1,
    output logic signed [TAP_W-1:0] filter_r_t2,
    output logic signed [TAP_W-1:0] filter_r_t3,
    output logic signed [TAP_W-1:0] filter_r_t4,
    output logic signed [TAP_W-1:0] filter_r_t5,
    output logic signed [TAP_W-1:0] filter_r_t6,
    output logic signed [TAP_W-1:0] filter_r_t7,
    output logic signed [TAP_W-1:0] filter_r_t8,
    output logic signed [TAP_W-1:0] filter_g_t0,
    output logic signed [TAP_W-1:0] filter_g_t1,
    output logic signed [TAP_W-1:0] filter_g_t2,
    output logic signed [TAP_W-1:0] filter_g_t3,
    output logic signed [TAP_W-1:0] filter_g_t4,
    output logic signed [TAP_W-1:0] filter_g_t5,
    output logic signed [TAP_W-1:0] filter_g_t6,
    output logic signed [TAP_W-1:0] filter_g_t7,
    output logic signed [TAP_W-1:0] filter_g_t8,
    output logic signed [TAP_W-1:0] filter_b_t0,
    output logic signed [TAP_W-1:0] filter_b_t1,
    output logic signed [TAP_W-1:0] filter_b_t2,
    output logic signed [TAP_W-1:0] filter_b_t3,
    output logic signed [TAP_W-1:0] filter_b_t4,
    output logic signed [TAP_W-1:0] filter_b_t5,
    output logic signed [TAP_W-1:0] filter_b_t6,
    output logic signed [TAP_W-1:0] filter_b_t7,
    output logic signed [TAP_W-1:0] filter_b_t8,
    output logic                    mac_en,
    output logic                    mac_clr,
    output logic                    output_en,
    output logic                    frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_e          state_q, state_d;
    logic            ready_q, ready_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            hs;
    logic            last_px;
    logic            first_px;
    logic [23:0]     lb1, lb2;
    logic [23:0]     win_q [3][3];
    logic            win_vld_q;
    logic [71:0]     coef_q;
    logic            mac_clr_q;
    logic            mac_en_q;
    logic            out_en_q;
    logic            first_done_q;
    logic            fl1_q, fl2_q, fl3_q;
    logic            done_q;
    tap_t            prod_r [NTAPS];
    tap_t            prod_g [NTAPS];
    tap_t            prod_b [NTAPS];
    tap_t            tap_r_q [NTAPS];
    tap_t            tap_g_q [NTAPS];
    tap_t            tap_b_q [NTAPS];

    assign pixel_ready = ready_q;
    assign hs          = pixel_valid & ready_q;
    assign last_px     = hs && (row_q == RW'(IMG_H-1))
                            && (col_q == CW'(IMG_W-1));
    assign first_px    = hs && (row_q == '0) && (col_q == '0);

    // Frame sequencing: stream, one flush cycle, one drain cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_STREAM: if (last_px) state_d = S_FLUSH;
            S_FLUSH:  state_d = S_DRAIN;
            S_DRAIN:  state_d = S_STREAM;
            default:  state_d = S_STREAM;
        endcase
        ready_d = (state_d == S_STREAM);
    end

    // State and ready registers; ready stays low through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_STREAM;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // Raster position: col wraps into row, cleared while draining.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (state_q == S_DRAIN) begin
            col_d = '0;
            row_d = '0;
        end else if (hs) begin
            if (col_q == CW'(IMG_W-1)) begin
                col_d = '0;
                if (row_q == RW'(IMG_H-1)) row_d = '0;
                else                       row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    fir_line_buffer #(
        .DEPTH (IMG_W),
        .AW    (CW)
    ) u_lb (
        .clk     (clk),
        .we_i    (hs),
        .addr_i  (col_q),
        .din_i   (pixel_in),
        .line1_o (lb1),
        .line2_o (lb2)
    );

    // Window shifts left; newest column enters on the right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            win_vld_q <= 1'b0;
        end else begin
            if (hs) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb2;
                win_q[1][2] <= lb1;
                win_q[2][2] <= pixel_in;
            end
            win_vld_q <= hs && (row_q >= RW'(2)) && (col_q >= CW'(2));
        end
    end

    // Coefficients are frozen at the first pixel of each frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_q    <= '0;
            mac_clr_q <= 1'b0;
        end else begin
            if (first_px) coef_q <= coef_flat;
            mac_clr_q <= first_px;
        end
    end

    // Per-tap products for all three channels.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            prod_r[k] = tap_mul(win_q[k/3][k%3][23:16], coef_q[8*k +: 8]);
            prod_g[k] = tap_mul(win_q[k/3][k%3][15:8],  coef_q[8*k +: 8]);
            prod_b[k] = tap_mul(win_q[k/3][k%3][7:0],   coef_q[8*k +: 8]);
        end
    end

    // Tap registers: zero on flush, products on a valid window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                tap_r_q[k] <= '0;
                tap_g_q[k] <= '0;
                tap_b_q[k] <= '0;
            end
            mac_en_q <= 1'b0;
        end else begin
            if (fl1_q) begin
                for (int k = 0; k < NTAPS; k++) begin
                    tap_r_q[k] <= '0;
                    tap_g_q[k] <= '0;
                    tap_b_q[k] <= '0;
                end
            end else if (win_vld_q) begin
                for (int k = 0; k < NTAPS; k++) begin
                    tap_r_q[k] <= prod_r[k];
                    tap_g_q[k] <= prod_g[k];
                    tap_b_q[k] <= prod_b[k];
                end
            end
            mac_en_q <= fl1_q | win_vld_q;
        end
    end

    // Flush delay line and output_en gating after the first pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fl1_q        <= 1'b0;
            fl2_q        <= 1'b0;
            fl3_q        <= 1'b0;
            done_q       <= 1'b0;
            first_done_q <= 1'b0;
            out_en_q     <= 1'b0;
        end else begin
            fl1_q    <= (state_q == S_FLUSH);
            fl2_q    <= fl1_q;
            fl3_q    <= fl2_q;
            done_q   <= fl3_q;
            out_en_q <= mac_en_q & first_done_q;
            if (first_px)      first_done_q <= 1'b0;
            else if (mac_en_q) first_done_q <= 1'b1;
        end
    end

    assign mac_en     = mac_en_q;
    assign mac_clr    = mac_clr_q;
    assign output_en  = out_en_q;
    assign frame_done = done_q;

    assign filter_r_t0 = tap_r_q[0];
    assign filter_r_t1 = tap_r_q[1];
    assign filter_r_t2 = tap_r_q[2];
    assign filter_r_t3 = tap_r_q[3];
    assign filter_r_t4 = tap_r_q[4];
    assign filter_r_t5 = tap_r_q[5];
    assign filter_r_t6 = tap_r_q[6];
    assign filter_r_t7 = tap_r_q[7];
    assign filter_r_t8 = tap_r_q[8];
    assign filter_g_t0 = tap_g_q[0];
    assign filter_g_t1 = tap_g_q[1];
    assign filter_g_t2 = tap_g_q[2];
    assign filter_g_t3 = tap_g_q[3];
    assign filter_g_t4 = tap_g_q[4];
    assign filter_g_t5 = tap_g_q[5];
    assign filter_g_t6 = tap_g_q[6];
    assign filter_g_t7 = tap_g_q[7];
    assign filter_g_t8 = tap_g_q[8];
    assign filter_b_t0 = tap_b_q[0];
    assign filter_b_t1 = tap_b_q[1];
    assign filter_b_t2 = tap_b_q[2];
    assign filter_b_t3 = tap_b_q[3];
    assign filter_b_t4 = tap_b_q[4];
    assign filter_b_t5 = tap_b_q[5];
    assign filter_b_t6 = tap_b_q[6];
    assign filter_b_t7 = tap_b_q[7];
    assign filter_b_t8 = tap_b_q[8];

endmodule

// File: tb/tb_fir_filter_window_mac.sv
// Directed bench for fir_filter_window_mac on a 4x4 frame.
// Captures every mac_en beat and compares against hand values and a window model.
module tb_fir_filter_window_mac;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = (W-2)*(H-2);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] pixel_in = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic [71:0] coef_flat = '0;
    logic signed [16:0] tr [9];
    logic signed [16:0] tg [9];
    logic signed [16:0] tbv [9];
    logic        mac_en, mac_clr, output_en, frame_done;

    always #5 clk = ~clk;

    fir_filter_window_mac #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .coef_flat(coef_flat),
        .filter_r_t0(tr[0]), .filter_r_t1(tr[1]), .filter_r_t2(tr[2]),
        .filter_r_t3(tr[3]), .filter_r_t4(tr[4]), .filter_r_t5(tr[5]),
        .filter_r_t6(tr[6]), .filter_r_t7(tr[7]), .filter_r_t8(tr[8]),
        .filter_g_t0(tg[0]), .filter_g_t1(tg[1]), .filter_g_t2(tg[2]),
        .filter_g_t3(tg[3]), .filter_g_t4(tg[4]), .filter_g_t5(tg[5]),
        .filter_g_t6(tg[6]), .filter_g_t7(tg[7]), .filter_g_t8(tg[8]),
        .filter_b_t0(tbv[0]), .filter_b_t1(tbv[1]), .filter_b_t2(tbv[2]),
        .filter_b_t3(tbv[3]), .filter_b_t4(tbv[4]), .filter_b_t5(tbv[5]),
        .filter_b_t6(tbv[6]), .filter_b_t7(tbv[7]), .filter_b_t8(tbv[8]),
        .mac_en(mac_en), .mac_clr(mac_clr),
        .output_en(output_en), .frame_done(frame_done)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    logic signed [16:0] cap [64][27];
    int cap_cyc [64];
    int ncap = 0, oe_cnt = 0, fd_cnt = 0, clr_cnt = 0, rdy_lo = 0, fd_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mac_en && ncap < 64) begin
                for (int k = 0; k < 9; k++) begin
                    cap[ncap][k]    = tr[k];
                    cap[ncap][9+k]  = tg[k];
                    cap[ncap][18+k] = tbv[k];
                end
                cap_cyc[ncap] = cyc;
                ncap++;
            end
            if (output_en) oe_cnt++;
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (mac_clr) clr_cnt++;
            if (!pixel_ready) rdy_lo++;
        end
    end

    int f_mode [6];
    int f_coef [6][9];
    int f_base [6];

    typedef struct {
        string name;
        int    frm;
        int    win;
        int    ch;
        int    tap;
        int    exp;
    } vec_t;
    vec_t vt [13];

    function automatic int pix_of(input int mode, input int idx, input int ch);
        if (mode == 0) return idx;
        if (mode == 1) return 255;
        return (idx*37 + ch*71 + 13) % 256;
    endfunction

    function automatic logic [71:0] pack_coef(input int frm);
        logic [71:0] v;
        int c;
        v = '0;
        for (int k = 0; k < 9; k++) begin
            c = f_coef[frm][k];
            v[8*k +: 8] = c[7:0];
        end
        return v;
    endfunction

    function automatic int model(input int frm, input int w, input int k, input int ch);
        int wr, wc, r, c;
        if (w >= N) return 0;
        wr = 2 + w / (W-2);
        wc = 2 + w % (W-2);
        r = wr - 2 + k / 3;
        c = wc - 2 + k % 3;
        return pix_of(f_mode[frm], r*W + c, ch) * f_coef[frm][k];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_frame(input int frm, input int npix, input bit gaps);
        int sent;
        int guard;
        bit hs;
        logic [71:0] cf;
        int md;
        sent = 0;
        guard = 0;
        cf = pack_coef(frm);
        md = f_mode[frm];
        while (sent < npix && guard < 4000) begin
            @(negedge clk);
            guard++;
            coef_flat = (sent == 0) ? cf : ~cf;
            pixel_in = {8'(pix_of(md, sent, 0)), 8'(pix_of(md, sent, 1)),
                        8'(pix_of(md, sent, 2))};
            pixel_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            hs = pixel_valid && pixel_ready;
            @(posedge clk);
            if (hs) sent++;
        end
        #1 pixel_valid = 1'b0;
        check($sformatf("send_f%0d_count", frm), sent, npix);
    endtask

    task automatic wait_fd(input int target);
        int g;
        g = 0;
        while (fd_cnt < target && g < 300) begin
            @(posedge clk);
            g++;
        end
        check("frame_done_arrived", int'(fd_cnt >= target), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input int frm);
        for (int w = 0; w <= N; w++) begin
            for (int ch = 0; ch < 3; ch++) begin
                for (int k = 0; k < 9; k++) begin
                    check($sformatf("f%0d_w%0d_c%0d_t%0d", frm, w, ch, k),
                          int'(cap[f_base[frm]+w][ch*9+k]),
                          model(frm, w, k, ch));
                end
            end
        end
    endtask

    int s_cap, s_oe, s_fd, s_clr, s_rdy;

    task automatic snap();
        s_cap = ncap;
        s_oe  = oe_cnt;
        s_fd  = fd_cnt;
        s_clr = clr_cnt;
        s_rdy = rdy_lo;
    endtask

    task automatic check_counts(input string tag, input int frames);
        check({tag, "_mac_en"},     ncap - s_cap,    frames*(N+1));
        check({tag, "_output_en"},  oe_cnt - s_oe,   frames*N);
        check({tag, "_frame_done"}, fd_cnt - s_fd,   frames);
        check({tag, "_mac_clr"},    clr_cnt - s_clr, frames);
        check({tag, "_ready_low"},  rdy_lo - s_rdy,  frames*2);
    endtask

    initial begin
        vt[0]  = '{"id_w0_r_t4",   0, 0, 0, 4, 5};
        vt[1]  = '{"id_w1_r_t4",   0, 1, 0, 4, 6};
        vt[2]  = '{"id_w2_g_t4",   0, 2, 1, 4, 9};
        vt[3]  = '{"id_w3_b_t4",   0, 3, 2, 4, 10};
        vt[4]  = '{"id_w0_r_t0",   0, 0, 0, 0, 0};
        vt[5]  = '{"id_flush_t4",  0, 4, 0, 4, 0};
        vt[6]  = '{"ext_w0_r_t0",  1, 0, 0, 0, -32640};
        vt[7]  = '{"ext_w0_r_t8",  1, 0, 0, 8, 32385};
        vt[8]  = '{"ext_w3_g_t0",  1, 3, 1, 0, -32640};
        vt[9]  = '{"ext_w3_b_t8",  1, 3, 2, 8, 32385};
        vt[10] = '{"ext_w2_r_t4",  1, 2, 0, 4, 0};
        vt[11] = '{"bp_w3_r_t4",   3, 3, 0, 4, 10};
        vt[12] = '{"ext_flush_t8", 1, 4, 2, 8, 0};

        for (int f = 0; f < 6; f++)
            for (int k = 0; k < 9; k++)
                f_coef[f][k] = 0;
        f_mode[0] = 0; f_coef[0][4] = 1;
        f_mode[1] = 1; f_coef[1][0] = -128; f_coef[1][8] = 127;
        f_mode[2] = 2;
        f_coef[2][0] = 3;    f_coef[2][1] = -5;  f_coef[2][2] = 7;
        f_coef[2][3] = -2;   f_coef[2][4] = 1;   f_coef[2][5] = 0;
        f_coef[2][6] = -128; f_coef[2][7] = 127; f_coef[2][8] = -1;
        f_mode[3] = 0; f_coef[3][4] = 1;
        f_mode[4] = 2;
        for (int k = 0; k < 9; k++)
            f_coef[4][k] = (k % 2 == 0) ? (k + 1) : -(k * 3);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pixel_ready", int'(pixel_ready), 0);
        check("rst_mac_en",      int'(mac_en), 0);
        check("rst_mac_clr",     int'(mac_clr), 0);
        check("rst_output_en",   int'(output_en), 0);
        check("rst_frame_done",  int'(frame_done), 0);
        check("rst_r_t4",        int'(tr[4]), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", int'(pixel_ready), 1);

        snap();
        f_base[0] = ncap;
        send_frame(0, W*H, 1'b0);
        wait_fd(s_fd + 1);
        check_counts("id", 1);
        check("id_done_gap", fd_cyc - cap_cyc[f_base[0]+N], 2);
        check_frame(0);

        snap();
        f_base[1] = ncap;
        f_base[2] = ncap + N + 1;
        send_frame(1, W*H, 1'b0);
        send_frame(2, W*H, 1'b0);
        wait_fd(s_fd + 2);
        check_counts("b2b", 2);
        check("ext_r_t0_bits",
              int'($unsigned(cap[f_base[1]][0])), 32'h18080);
        check_frame(1);
        check_frame(2);

        snap();
        f_base[3] = ncap;
        send_frame(3, W*H, 1'b1);
        wait_fd(s_fd + 1);
        check_counts("bp", 1);
        check_frame(3);

        send_frame(0, 12, 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_mac_en", int'(mac_en), 1);
        check("pre_rst_r_t4",   int'(tr[4]), 6);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_mac_en",      int'(mac_en), 0);
        check("mid_rst_r_t4",        int'(tr[4]), 0);
        check("mid_rst_pixel_ready", int'(pixel_ready), 0);
        snap();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_mac_en",     ncap - s_cap, 0);
        check("post_rst_output_en",  oe_cnt - s_oe, 0);
        check("post_rst_frame_done", fd_cnt - s_fd, 0);

        snap();
        f_base[4] = ncap;
        send_frame(4, W*H, 1'b0);
        wait_fd(s_fd + 1);
        check_counts("after_rst", 1);
        check_frame(4);

        for (int i = 0; i < 13; i++) begin
            check(vt[i].name,
                  int'(cap[f_base[vt[i].frm]+vt[i].win][vt[i].ch*9+vt[i].tap]),
                  vt[i].exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
